// File: rtl/interp_stream_pkg.sv
`default_nettype none
// ============================================================================
//  interp_stream_pkg
//  Shared types and chunk-selection helper for the interpreter stream port.
//  Revision: 1.0
// ============================================================================
package interp_stream_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        ACK    = 3'd3,
        NEXT   = 3'd4
    } ser_state_t;

    localparam int unsigned CHUNK_MAX_W = 256;

    // Returns chunk number idx (in transmission order), right-aligned in the result.
    function automatic logic [CHUNK_MAX_W-1:0] chunk_sel(
        input logic [CHUNK_MAX_W-1:0] word,
        input int unsigned            idx,
        input logic                   msb_first,
        input int unsigned            data_w,
        input int unsigned            out_w
    );
        int unsigned              pos;
        logic [CHUNK_MAX_W-1:0]   mask;
        pos  = msb_first ? (data_w / out_w - 1 - idx) : idx;
        mask = ~({CHUNK_MAX_W{1'b1}} << out_w);
        return (word >> (pos * out_w)) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interp_stream_port_if.sv
`default_nettype none
// ============================================================================
//  interp_stream_port_if
//  CPU capture, host handshake and status bundle for interp_stream_port.
//  Revision: 1.0
// ============================================================================
interface interp_stream_port_if #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 8,
    parameter int DEPTH  = 16
);
    logic                     com;
    logic                     mem_to_reg;
    logic [DATA_W-1:0]        read_data;
    logic                     end_flag;
    logic                     host_ready;
    logic [OUT_W-1:0]         out_data;
    logic                     clk_out;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     overflow;
    logic                     busy;
    logic                     done;

    modport master (
        output com, mem_to_reg, read_data, end_flag, host_ready,
        input  out_data, clk_out, fifo_count, overflow, busy, done
    );

    modport slave (
        input  com, mem_to_reg, read_data, end_flag, host_ready,
        output out_data, clk_out, fifo_count, overflow, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  sync_fifo
//  Show-ahead synchronous FIFO; a push while full succeeds only with a pop.
//  Revision: 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule
`default_nettype wire

// File: rtl/interp_stream_port.sv
`default_nettype none
// ============================================================================
//  interp_stream_port
//  Buffers CPU load words and streams them to the host as strobed chunks.
//  Revision: 1.0
// ============================================================================
module interp_stream_port
    import interp_stream_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 16,
    parameter int MSB_FIRST = 0,
    parameter int STROBE_HI = 2,
    parameter int USE_ACK   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    interp_stream_port_if.slave  bus
);
    localparam int NCH   = DATA_W / OUT_W;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SCW   = $clog2(STROBE_HI + 1);

    generate
        if ((DATA_W % OUT_W) != 0 || DATA_W > int'(CHUNK_MAX_W)) begin : g_bad_width
            $error("interp_stream_port: DATA_W must be a multiple of OUT_W and <= CHUNK_MAX_W");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("interp_stream_port: DEPTH must be a power of two >= 2");
        end
        if (STROBE_HI < 1) begin : g_bad_strobe
            $error("interp_stream_port: STROBE_HI must be >= 1");
        end
    endgenerate

    logic                    capture;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [DATA_W-1:0]       rdata;
    logic [CW-1:0]           count;

    ser_state_t              state, state_nx;
    logic [DATA_W-1:0]       shreg, shreg_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic [OUT_W-1:0]        out_data, out_nx;
    logic                    clk_out, clk_out_nx;
    logic [SCW-1:0]          scnt, scnt_nx;
    logic                    overflow;
    logic                    end_seen;
    logic                    done;
    logic [CHUNK_MAX_W-1:0]  chunk_wide;

    assign capture = bus.com & bus.mem_to_reg;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (capture),
        .pop   (pop),
        .wdata (bus.read_data),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign chunk_wide = chunk_sel(CHUNK_MAX_W'(shreg), 32'(idx), (MSB_FIRST != 0),
                                  unsigned'(DATA_W), unsigned'(OUT_W));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            idx      <= '0;
            out_data <= '0;
            clk_out  <= 1'b0;
            scnt     <= '0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            idx      <= idx_nx;
            out_data <= out_nx;
            clk_out  <= clk_out_nx;
            scnt     <= scnt_nx;
        end
    end

    // clk_out is registered, so STROBE spends one extra cycle dropping it before leaving.
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        idx_nx     = idx;
        out_nx     = out_data;
        clk_out_nx = 1'b0;
        scnt_nx    = '0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shreg_nx = rdata;
                    idx_nx   = '0;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                out_nx   = chunk_wide[OUT_W-1:0];
                state_nx = STROBE;
            end
            STROBE: begin
                if (scnt == SCW'(STROBE_HI)) begin
                    state_nx = (USE_ACK != 0) ? ACK : NEXT;
                end else begin
                    clk_out_nx = 1'b1;
                    scnt_nx    = scnt + 1'b1;
                end
            end
            ACK: begin
                if (bus.host_ready) state_nx = NEXT;
            end
            NEXT: begin
                if (idx == IDX_W'(NCH - 1)) begin
                    state_nx = IDLE;
                end else begin
                    idx_nx   = idx + 1'b1;
                    state_nx = SETUP;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            end_seen <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (capture && full && !pop)                   overflow <= 1'b1;
            if (bus.end_flag)                              end_seen <= 1'b1;
            if (end_seen && count == '0 && state == IDLE)  done     <= 1'b1;
        end
    end

    assign bus.out_data   = out_data;
    assign bus.clk_out    = clk_out;
    assign bus.fifo_count = count;
    assign bus.overflow   = overflow;
    assign bus.busy       = (state != IDLE) | ~empty;
    assign bus.done       = done;
endmodule
`default_nettype wire

// File: tb/tb_interp_stream_port.sv
`default_nettype none
// ============================================================================
//  tb_interp_stream_port
//  Directed bench: three DUT configurations sharing one clock and reset.
//  Revision: 1.0
// ============================================================================
module tb_interp_stream_port;
    logic clk;
    logic reset;
    int   tests  = 0;
    int   failed = 0;

    interp_stream_port_if #(.DATA_W(32), .OUT_W(8), .DEPTH(16)) ba ();
    interp_stream_port_if #(.DATA_W(32), .OUT_W(8), .DEPTH(16)) bb ();
    interp_stream_port_if #(.DATA_W(32), .OUT_W(8), .DEPTH(4))  bc ();

    interp_stream_port #(.DATA_W(32), .OUT_W(8), .DEPTH(16), .MSB_FIRST(0), .STROBE_HI(2), .USE_ACK(1))
        u_a (.clk(clk), .reset(reset), .bus(ba.slave));
    interp_stream_port #(.DATA_W(32), .OUT_W(8), .DEPTH(16), .MSB_FIRST(1), .STROBE_HI(2), .USE_ACK(1))
        u_b (.clk(clk), .reset(reset), .bus(bb.slave));
    interp_stream_port #(.DATA_W(32), .OUT_W(8), .DEPTH(4), .MSB_FIRST(0), .STROBE_HI(2), .USE_ACK(1))
        u_c (.clk(clk), .reset(reset), .bus(bc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitors: record the chunk at each clk_out rise, the high length, and any change while high.
    logic [7:0] qa[$], qb[$], qc[$];
    int         la[$], lb[$];
    int         unstable_a = 0, unstable_b = 0;
    logic       prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;
    logic [7:0] hold_a, hold_b;
    int         hi_a = 0, hi_b = 0;

    always @(negedge clk) begin
        if (ba.clk_out && !prev_a) begin
            qa.push_back(ba.out_data); hold_a = ba.out_data; hi_a = 1;
        end else if (ba.clk_out) begin
            hi_a++;
            if (ba.out_data !== hold_a) unstable_a++;
        end else if (prev_a) begin
            la.push_back(hi_a);
        end
        prev_a = ba.clk_out;

        if (bb.clk_out && !prev_b) begin
            qb.push_back(bb.out_data); hold_b = bb.out_data; hi_b = 1;
        end else if (bb.clk_out) begin
            hi_b++;
            if (bb.out_data !== hold_b) unstable_b++;
        end else if (prev_b) begin
            lb.push_back(hi_b);
        end
        prev_b = bb.clk_out;

        if (bc.clk_out && !prev_c) qc.push_back(bc.out_data);
        prev_c = bc.clk_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cap_a(input logic [31:0] w0, input logic [31:0] w1, input int n);
        @(posedge clk); #1;
        ba.com = 1'b1; ba.mem_to_reg = 1'b1; ba.read_data = w0;
        @(posedge clk); #1;
        if (n > 1) begin
            ba.read_data = w1;
            @(posedge clk); #1;
        end
        ba.com = 1'b0; ba.mem_to_reg = 1'b0;
    endtask

    initial begin
        int early;
        int n;
        reset = 1'b0;
        ba.com = 0; ba.mem_to_reg = 0; ba.read_data = '0; ba.end_flag = 0; ba.host_ready = 1;
        bb.com = 0; bb.mem_to_reg = 0; bb.read_data = '0; bb.end_flag = 0; bb.host_ready = 1;
        bc.com = 0; bc.mem_to_reg = 0; bc.read_data = '0; bc.end_flag = 0; bc.host_ready = 0;

        // Reset state
        #22;
        check("rst_out_data", 32'(ba.out_data), 32'h0);
        check("rst_clk_out",  32'(ba.clk_out), 32'h0);
        check("rst_count",    32'(ba.fifo_count), 32'h0);
        check("rst_overflow", 32'(ba.overflow), 32'h0);
        check("rst_busy",     32'(ba.busy), 32'h0);
        check("rst_done",     32'(ba.done), 32'h0);
        @(negedge clk); #1 reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: LSB-first, ready tied high, latency per edge
        cap_a(32'hA1B2C3D4, 32'h0, 1);
        @(negedge clk);
        check("t1_count_e0", 32'(ba.fifo_count), 32'd1);
        check("t1_busy_e0",  32'(ba.busy), 32'd1);
        @(negedge clk);
        check("t1_count_e1", 32'(ba.fifo_count), 32'd0);
        @(negedge clk);
        check("t1_data_e2",  32'(ba.out_data), 32'hD4);
        check("t1_clk_e2",   32'(ba.clk_out), 32'd0);
        @(negedge clk);
        check("t1_clk_e3",   32'(ba.clk_out), 32'd1);
        repeat (40) @(negedge clk);
        check("t1_nchunks", 32'(qa.size()), 32'd4);
        if (qa.size() == 4) begin
            check("t1_c0", 32'(qa[0]), 32'hD4);
            check("t1_c1", 32'(qa[1]), 32'hC3);
            check("t1_c2", 32'(qa[2]), 32'hB2);
            check("t1_c3", 32'(qa[3]), 32'hA1);
        end
        check("t1_len_all2", 32'((la.size() == 4) && la[0] == 2 && la[1] == 2 && la[2] == 2 && la[3] == 2), 32'd1);
        check("t1_stable", 32'(unstable_a), 32'd0);
        check("t1_busy_end", 32'(ba.busy), 32'd0);

        // 2: MSB-first
        @(posedge clk); #1;
        bb.com = 1; bb.mem_to_reg = 1; bb.read_data = 32'h01020304;
        @(posedge clk); #1;
        bb.com = 0; bb.mem_to_reg = 0;
        repeat (40) @(negedge clk);
        check("t2_nchunks", 32'(qb.size()), 32'd4);
        if (qb.size() == 4) begin
            check("t2_c0", 32'(qb[0]), 32'h01);
            check("t2_c1", 32'(qb[1]), 32'h02);
            check("t2_c2", 32'(qb[2]), 32'h03);
            check("t2_c3", 32'(qb[3]), 32'h04);
        end
        check("t2_stable", 32'(unstable_b), 32'd0);
        check("t2_len0", 32'((lb.size() > 0) ? lb[0] : 0), 32'd2);

        // 3: park in ACK, then a single ready pulse advances one chunk
        qa.delete(); la.delete();
        ba.host_ready = 0;
        cap_a(32'h11223344, 32'h0, 1);
        repeat (25) @(negedge clk);
        check("t3_park_clk",  32'(ba.clk_out), 32'd0);
        check("t3_park_data", 32'(ba.out_data), 32'h44);
        check("t3_park_n",    32'(qa.size()), 32'd1);
        check("t3_park_busy", 32'(ba.busy), 32'd1);
        @(posedge clk); #1 ba.host_ready = 1;
        @(posedge clk); #1 ba.host_ready = 0;
        repeat (10) @(negedge clk);
        check("t3_step_n",    32'(qa.size()), 32'd2);
        check("t3_step_data", 32'(ba.out_data), 32'h33);
        check("t3_step_clk",  32'(ba.clk_out), 32'd0);
        ba.host_ready = 1;
        repeat (30) @(negedge clk);
        check("t3_nchunks", 32'(qa.size()), 32'd4);
        if (qa.size() == 4) begin
            check("t3_c2", 32'(qa[2]), 32'h22);
            check("t3_c3", 32'(qa[3]), 32'h11);
        end
        check("t3_busy_end", 32'(ba.busy), 32'd0);

        // 4: DEPTH=4 overflow; word 1 is popped on edge 1, words 2-5 fill, word 6 is dropped
        @(posedge clk); #1;
        bc.com = 1; bc.mem_to_reg = 1;
        for (int k = 1; k <= 6; k++) begin
            bc.read_data = 32'h01010101 * 32'(k);
            @(posedge clk); #1;
        end
        bc.com = 0; bc.mem_to_reg = 0;
        @(negedge clk);
        check("t4_count_full", 32'(bc.fifo_count), 32'd4);
        check("t4_overflow",   32'(bc.overflow), 32'd1);
        repeat (10) @(negedge clk);
        check("t4_held_count", 32'(bc.fifo_count), 32'd4);
        check("t4_held_n",     32'(qc.size()), 32'd1);
        bc.host_ready = 1;
        repeat (200) @(negedge clk);
        check("t4_nchunks", 32'(qc.size()), 32'd20);
        if (qc.size() == 20) begin
            check("t4_w1", 32'(qc[0]),  32'h01);
            check("t4_w2", 32'(qc[4]),  32'h02);
            check("t4_w5", 32'(qc[16]), 32'h05);
            check("t4_w5_last", 32'(qc[19]), 32'h05);
        end
        check("t4_count_end", 32'(bc.fifo_count), 32'd0);
        check("t4_busy_end",  32'(bc.busy), 32'd0);
        check("t4_ovf_sticky", 32'(bc.overflow), 32'd1);

        // 5: done waits for the queue to drain and the FSM to return to IDLE
        qa.delete();
        cap_a(32'h55667788, 32'h99AABBCC, 2);
        ba.end_flag = 1;
        @(posedge clk); #1 ba.end_flag = 0;
        @(negedge clk);
        check("t5_done_early", 32'(ba.done), 32'd0);
        early = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!ba.busy) break;
            if (ba.done) early++;
        end
        check("t5_drained", 32'(ba.busy), 32'd0);
        check("t5_no_early", 32'(early), 32'd0);
        check("t5_done_idle0", 32'(ba.done), 32'd0);
        @(negedge clk);
        check("t5_done_set", 32'(ba.done), 32'd1);
        check("t5_nchunks", 32'(qa.size()), 32'd8);
        if (qa.size() == 8) check("t5_c4", 32'(qa[4]), 32'hCC);
        cap_a(32'h0F0E0D0C, 32'h0, 1);
        repeat (40) @(negedge clk);
        check("t5_done_held", 32'(ba.done), 32'd1);
        check("t5_post_n", 32'(qa.size()), 32'd12);
        if (qa.size() == 12) check("t5_post_c0", 32'(qa[8]), 32'h0C);

        // 6: reset during the strobe of chunk 2
        qa.delete();
        cap_a(32'hCAFEF00D, 32'h12345678, 2);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (qa.size() == 2) break;
        end
        check("t6_in_strobe", 32'(ba.clk_out), 32'd1);
        check("t6_chunk2",    32'(ba.out_data), 32'hF0);
        check("t6_queued",    32'(ba.fifo_count), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_clk",   32'(ba.clk_out), 32'd0);
        check("t6_rst_data",  32'(ba.out_data), 32'h0);
        check("t6_rst_count", 32'(ba.fifo_count), 32'd0);
        check("t6_rst_done",  32'(ba.done), 32'd0);
        check("t6_rst_busy",  32'(ba.busy), 32'd0);
        check("t6_rst_ovf_c", 32'(bc.overflow), 32'd0);
        n = qa.size();
        @(negedge clk); #1 reset = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_no_residual", 32'(qa.size()), 32'(n));
        check("t6_idle_busy",   32'(ba.busy), 32'd0);
        check("t6_idle_clk",    32'(ba.clk_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
`default_nettype wire
